multiword_addsub_seq: RTL and testbench

Sequencer that performs WIDTH-bit add or subtract by reusing a single 4-bit ripple-carry adder one nibble per clock, LSB nibble first, with the carry held in a register between cycles. It sits between the processor's ALU control and the shared 4-bit adder datapath, trading latency for area. Start/done handshake; the result is held stable until the next operation completes.

---
 rtl/multiword_addsub_seq_pkg.sv | 17 +
 rtl/multiword_addsub_seq_ripple_carry_n.sv | 26 ++
 rtl/multiword_addsub_seq.sv | 113 +++++++++++
 tb/tb_multiword_addsub_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/multiword_addsub_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// Holds the state encoding and the adder slice width.
package multiword_addsub_seq_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DONE = DONE
    } state_t;

endpackage

// File: rtl/multiword_addsub_seq_ripple_carry_n.sv
// N-bit ripple-carry adder built from a chain of full-adder cells.
// This is the shared datapath adder that the sequencer time-multiplexes.
module ripple_carry_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    // NOTE: the running carry is a blocking temporary inside always_comb;
    // every output gets a default first so no latch is inferred.
    always_comb begin
        logic w_c;
        o_sum = '0;
        w_c   = i_cin;
        for (int i = 0; i < N; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/multiword_addsub_seq.sv
// WIDTH-bit add/subtract performed one nibble per clock through a single
// 4-bit ripple adder, LSB nibble first, with the carry held between steps.
module multiword_addsub_seq
    import multiword_addsub_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int N     = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic [NIB_W-1:0] w_nib_sum;
    logic             w_nib_cout;
    logic             w_ovf;

    ripple_carry_n #(
        .N (NIB_W)
    ) u_adder (
        .i_a    (r_a[NIB_W*int'(r_idx) +: NIB_W]),
        .i_b    (r_b[NIB_W*int'(r_idx) +: NIB_W]),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    // B already holds ~b for subtraction, so this is the plain addition rule.
    assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                   (w_nib_sum[NIB_W-1] != r_a[WIDTH-1]);

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc[NIB_W*int'(r_idx) +: NIB_W] <= w_nib_sum;
                    r_carry <= w_nib_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        // The top nibble is not in r_acc yet, so splice it in.
                        r_sum   <= {w_nib_sum, r_acc[WIDTH-NIB_W-1:0]};
                        r_cout  <= w_nib_cout;
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Directed bench for multiword_addsub_seq (WIDTH=16) with a scoreboard queue
// filled by the stimulus and drained by a done-driven monitor.
module tb_multiword_addsub_seq;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    exp_t             exp_q[$];
    int               total;
    int               bad;
    int               n_pushed;
    int               n_done;
    logic [WIDTH-1:0] last_sum;

    multiword_addsub_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_sub   (sub),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout),
        .o_ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_sum", 32'(sum), 32'(e.sum));
                check("sb_cout", 32'(cout), 32'(e.cout));
                check("sb_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; optionally pester the DUT with ignored starts
    // and changing operands while it is busy and in its done cycle.
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic op_sub, input logic [WIDTH-1:0] e_sum,
                          input logic e_cout, input logic e_ovf, input logic poke);
        exp_t e;
        int   busy_cycles;
        int   done_at;
        e.sum  = e_sum;
        e.cout = e_cout;
        e.ovf  = e_ovf;
        exp_q.push_back(e);
        n_pushed++;
        start = 1'b1;
        sub   = op_sub;
        a     = op_a;
        b     = op_b;
        tick();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        sub   = 1'($urandom);
        busy_cycles = 0;
        done_at     = -1;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
            if (busy === 1'b1) begin
                busy_cycles++;
                check("sum_held", 32'(sum), 32'(last_sum));
            end
            if (poke) begin
                start = ~start;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                sub   = ~sub;
            end
            tick();
        end
        check("done_edge", 32'(done_at), 32'(N));
        check("busy_cycles", 32'(busy_cycles), 32'(N));
        if (poke) start = 1'b1;
        tick();
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
        tick();
        check("no_retrigger", 32'(busy), 32'd0);
        last_sum = e_sum;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        n_pushed = 0;
        n_done   = 0;
        last_sum = '0;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        run_op(16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op(16'h0003, 16'h0003, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

        // Abort an operation with rst in its second RUN cycle.
        start = 1'b1;
        sub   = 1'b0;
        a     = 16'hAAAA;
        b     = 16'h1111;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        repeat (N + 3) tick();
        check("abort_still_idle", 32'(busy), 32'd0);
        last_sum = '0;
        run_op(16'hABCD, 16'h1234, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0);

        repeat (3) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
